// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 host transmit path.
// Contents: FSM state encoding, frame bit positions, counter widths,
// common mouse command bytes and the odd-parity helper.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        START,
        SHIFT,
        ACK,
        RELEASE,
        DONE,
        ERR
    } ps2_state_t;

    localparam int DATA_BITS  = 8;
    localparam int PARITY_IDX = 8;
    localparam int STOP_IDX   = 9;

    localparam int INH_W = 14;
    localparam int TO_W  = 21;
    localparam int IDX_W = 4;

    localparam logic [7:0] CMD_RESET    = 8'hFF;
    localparam logic [7:0] CMD_ENABLE   = 8'hF4;
    localparam logic [7:0] CMD_SET_RATE = 8'hF3;

    // Odd parity: the parity bit makes the total count of ones odd.
    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Conditioning for one raw PS/2 pad: 2-flop synchronizer, debounce filter
// and a single-cycle falling-edge strobe on the filtered value.
// Ports:
//   clk, rst   system clock, async active-low reset
//   raw        raw pad value
//   level      filtered line value (resets to 1, the idle bus level)
//   fall       one-cycle pulse when level goes 1 -> 0
module ps2_line_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic fall
);

    localparam int CW = $clog2(FILTER_LEN + 1);

    logic          sync_1;
    logic          sync_2;
    logic [CW-1:0] cnt;

    // cnt counts consecutive synchronized samples that disagree with level;
    // any agreeing sample restarts the run, so short glitches are dropped.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_1 <= 1'b1;
            sync_2 <= 1'b1;
            cnt    <= '0;
            level  <= 1'b1;
            fall   <= 1'b0;
        end else begin
            sync_1 <= raw;
            sync_2 <= sync_1;
            fall   <= 1'b0;
            if (sync_2 == level) begin
                cnt <= '0;
            end else if (cnt == CW'(FILTER_LEN - 1)) begin
                level <= sync_2;
                cnt   <= '0;
                fall  <= ~sync_2;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: sends one command byte to the mouse
// over the open-drain clock/data lines and reports done or error.
// Ports:
//   clk, rst                  system clock, async active-low reset
//   tx_data, tx_valid         command byte and send request
//   tx_ready                  high only while idle
//   ps2_clk_in, ps2_data_in   raw pad values
//   ps2_clk_drive_low         1 = pull PS2Clk low (registered)
//   ps2_data_drive_low        1 = pull PS2Data low (registered)
//   busy                      frame in flight (receive path should ignore line)
//   tx_done, tx_err           one-cycle completion pulses
//
// state   | meaning
// IDLE    | lines released, waiting for a request
// INHIBIT | hold clock low to take the bus from the device
// START   | clock and data both low for one cycle (request to send)
// SHIFT   | clock released; data changes on each device clock fall
// ACK     | data released; sample device ACK on next fall
// RELEASE | wait for the device to let both lines go high
// DONE    | tx_done pulse
// ERR     | tx_err pulse (no ACK or timeout)
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 12000,
    parameter int TIMEOUT_CYCLES = 1500000,
    parameter int FILTER_LEN     = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_drive_low,
    output logic       ps2_data_drive_low,
    output logic       busy,
    output logic       tx_done,
    output logic       tx_err
);

    localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

    ps2_state_t       state;
    ps2_state_t       state_nxt;
    logic [7:0]       data_q;
    logic             par_q;
    logic [INH_W-1:0] inh_cnt;
    logic [TO_W-1:0]  to_cnt;
    logic [IDX_W-1:0] bit_idx;
    logic             clk_dl_nxt;
    logic             data_dl_nxt;
    logic             shift_bit;
    logic             accept;
    logic             timeout;
    logic             clk_filt;
    logic             clk_fall;
    logic             data_filt;
    logic             data_fall_unused;

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
        .clk   (clk),
        .rst   (rst),
        .raw   (ps2_clk_in),
        .level (clk_filt),
        .fall  (clk_fall)
    );

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filter (
        .clk   (clk),
        .rst   (rst),
        .raw   (ps2_data_in),
        .level (data_filt),
        .fall  (data_fall_unused)
    );

    assign tx_ready = (state == IDLE);
    assign busy     = (state != IDLE);
    assign accept   = tx_valid && tx_ready;
    assign timeout  = (to_cnt == TO_LAST);

    // Bit driven after the fall that carries bit_idx: data LSB first,
    // then parity, then the stop bit (released line).
    always_comb begin
        shift_bit = 1'b1;
        if (bit_idx < IDX_W'(DATA_BITS)) begin
            shift_bit = data_q[bit_idx[2:0]];
        end else if (bit_idx == IDX_W'(PARITY_IDX)) begin
            shift_bit = par_q;
        end
    end

    // Drive outputs are computed for the next state so that, once
    // registered, they line up exactly with the state they belong to.
    always_comb begin
        state_nxt   = state;
        clk_dl_nxt  = 1'b0;
        data_dl_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt  = INHIBIT;
                    clk_dl_nxt = 1'b1;
                end
            end
            INHIBIT: begin
                clk_dl_nxt = 1'b1;
                if (inh_cnt == INH_LAST) begin
                    state_nxt   = START;
                    data_dl_nxt = 1'b1;
                end
            end
            START: begin
                state_nxt   = SHIFT;
                data_dl_nxt = 1'b1;
            end
            SHIFT: begin
                data_dl_nxt = ps2_data_drive_low;
                if (timeout) begin
                    state_nxt   = ERR;
                    data_dl_nxt = 1'b0;
                end else if (clk_fall) begin
                    data_dl_nxt = ~shift_bit;
                    if (bit_idx == IDX_W'(STOP_IDX)) begin
                        state_nxt = ACK;
                    end
                end
            end
            ACK: begin
                if (timeout) begin
                    state_nxt = ERR;
                end else if (clk_fall) begin
                    state_nxt = data_filt ? ERR : RELEASE;
                end
            end
            RELEASE: begin
                if (timeout) begin
                    state_nxt = ERR;
                end else if (clk_filt && data_filt) begin
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            ERR:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state              <= IDLE;
            ps2_clk_drive_low  <= 1'b0;
            ps2_data_drive_low <= 1'b0;
            tx_done            <= 1'b0;
            tx_err             <= 1'b0;
            data_q             <= '0;
            par_q              <= 1'b0;
            inh_cnt            <= '0;
            to_cnt             <= '0;
            bit_idx            <= '0;
        end else begin
            state              <= state_nxt;
            ps2_clk_drive_low  <= clk_dl_nxt;
            ps2_data_drive_low <= data_dl_nxt;
            tx_done            <= (state_nxt == DONE);
            tx_err             <= (state_nxt == ERR);
            if (accept) begin
                data_q <= tx_data;
                par_q  <= odd_parity(tx_data);
            end
            inh_cnt <= (state == INHIBIT) ? inh_cnt + 1'b1 : '0;
            // Cleared in START (and everywhere else) so SHIFT begins at 0.
            to_cnt  <= (state == SHIFT || state == ACK || state == RELEASE) ?
                       to_cnt + 1'b1 : '0;
            if (state == SHIFT) begin
                if (clk_fall) begin
                    bit_idx <= bit_idx + 1'b1;
                end
            end else begin
                bit_idx <= '0;
            end
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
module tb_ps2_host_tx;

    // Shortened inhibit/timeout so the whole run stays small; the device
    // model clocks with a half period of H system cycles.
    localparam int INHIBIT = 300;
    localparam int TIMEOUT = 4000;
    localparam int FLEN    = 8;
    localparam int H       = 40;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] tx_data = '0;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic       ps2_clk_in;
    logic       ps2_data_in;
    logic       ps2_clk_drive_low;
    logic       ps2_data_drive_low;
    logic       busy;
    logic       tx_done;
    logic       tx_err;

    logic dev_clk = 1'b1;
    logic dev_data = 1'b1;
    logic glitch = 1'b0;
    bit   dev_enable = 1'b1;
    bit   dev_ack = 1'b1;
    bit   dev_glitch = 1'b0;
    bit   dev_active = 1'b0;

    int cyc = 0;
    int n_checks = 0;
    int n_pass = 0;
    int pulse_cnt = 0;

    typedef struct {
        logic [10:0] frame;
        bit          ok;
        bit          clocked;
    } exp_t;

    exp_t        exp_q[$];
    logic [10:0] cap_q[$];

    assign ps2_clk_in  = ~ps2_clk_drive_low & dev_clk & ~glitch;
    assign ps2_data_in = ~ps2_data_drive_low & dev_data;

    ps2_host_tx #(
        .INHIBIT_CYCLES (INHIBIT),
        .TIMEOUT_CYCLES (TIMEOUT),
        .FILTER_LEN     (FLEN)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .tx_data            (tx_data),
        .tx_valid           (tx_valid),
        .tx_ready           (tx_ready),
        .ps2_clk_in         (ps2_clk_in),
        .ps2_data_in        (ps2_data_in),
        .ps2_clk_drive_low  (ps2_clk_drive_low),
        .ps2_data_drive_low (ps2_data_drive_low),
        .busy               (busy),
        .tx_done            (tx_done),
        .tx_err             (tx_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Reference frame as the device sees it on rising clock edges:
    // start 0, data LSB first, odd parity, stop 1.
    function automatic logic [10:0] frame_of(input logic [7:0] b);
        logic [10:0] f;
        int ones;
        ones = 0;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            f[1 + i] = b[i];
            ones += int'(b[i]);
        end
        f[9]  = (ones % 2 == 0);
        f[10] = 1'b1;
        return f;
    endfunction

    // Device model: clocks the frame in, optionally ACKs.
    task automatic run_frame();
        logic [10:0] f;
        dev_active = 1'b1;
        f[0] = ps2_data_in;
        repeat (H) @(negedge clk);
        for (int k = 0; k < 10; k++) begin
            dev_clk = 1'b0;
            repeat (H) @(negedge clk);
            dev_clk = 1'b1;
            @(negedge clk);
            f[k + 1] = ps2_data_in;
            if (dev_glitch && k == 3) begin
                repeat (10) @(negedge clk);
                glitch = 1'b1;
                repeat (5) @(negedge clk);
                glitch = 1'b0;
            end
            repeat (H) @(negedge clk);
        end
        cap_q.push_back(f);
        if (dev_ack) dev_data = 1'b0;
        repeat (H) @(negedge clk);
        dev_clk = 1'b0;
        repeat (H) @(negedge clk);
        dev_clk = 1'b1;
        repeat (H) @(negedge clk);
        dev_data = 1'b1;
        dev_active = 1'b0;
    endtask

    initial begin : device
        logic prev;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (prev && !ps2_clk_drive_low && ps2_data_drive_low && dev_enable)
                run_frame();
            prev = ps2_clk_drive_low;
        end
    end

    // Scoreboard monitor: pops an expectation whenever the DUT reports.
    initial begin : monitor
        exp_t        e;
        logic [10:0] f;
        forever begin
            @(negedge clk);
            if (tx_done || tx_err) begin
                pulse_cnt++;
                check("pulse_expected", (exp_q.size() > 0) ? 1 : 0, 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("tx_done", tx_done, e.ok);
                    check("tx_err", tx_err, !e.ok);
                    if (e.clocked) begin
                        if (cap_q.size() > 0) begin
                            f = cap_q.pop_front();
                            check("frame_bits", f, e.frame);
                        end else begin
                            check("frame_captured", 0, 1);
                        end
                    end
                end
                @(negedge clk);
                check("pulse_width", tx_done | tx_err, 0);
                check("ready_after", tx_ready, 1);
                check("busy_after", busy, 0);
                check("lines_after", {ps2_clk_drive_low, ps2_data_drive_low}, 0);
            end
        end
    end

    // Issue one byte; checks the inhibit/start timing and returns the
    // cycle count at which SHIFT was entered.
    task automatic send(input logic [7:0] b, input bit ok, input bit clocked,
                        input bit push, output int t_shift);
        exp_t e;
        int   n;
        e.frame = frame_of(b);
        e.ok = ok;
        e.clocked = clocked;
        if (push) exp_q.push_back(e);
        tx_data  = b;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        tx_data  = 8'($urandom);
        n = 0;
        while (ps2_clk_drive_low && !ps2_data_drive_low && n < INHIBIT + 10) begin
            n++;
            @(negedge clk);
        end
        check("inhibit_len", n, INHIBIT);
        check("start_both_low", {ps2_clk_drive_low, ps2_data_drive_low}, 2'b11);
        @(negedge clk);
        check("shift_clk_released", {ps2_clk_drive_low, ps2_data_drive_low}, 2'b01);
        t_shift = cyc;
    endtask

    task automatic wait_idle(input int budget);
        int i;
        i = 0;
        while (busy && i < budget) begin
            @(negedge clk);
            i++;
        end
        check("frame_end", busy, 0);
        @(negedge clk);
    endtask

    initial begin : watchdog
        #(800000 * 10);
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int          t0;
        int          p0;
        int          n;
        logic [7:0]  b;
        logic [7:0]  fixed[3];

        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ready", tx_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_lines", {ps2_clk_drive_low, ps2_data_drive_low}, 0);
        check("rst_pulses", {tx_done, tx_err}, 0);
        rst = 1'b1;
        repeat (3) @(negedge clk);

        fixed[0] = ps2_pkg::CMD_ENABLE;
        fixed[1] = ps2_pkg::CMD_RESET;
        fixed[2] = 8'h00;
        for (int i = 0; i < 3; i++) begin
            send(fixed[i], 1'b1, 1'b1, 1'b1, t0);
            wait_idle(3 * TIMEOUT);
        end

        for (int i = 0; i < 6; i++) begin
            b = 8'($urandom);
            send(b, 1'b1, 1'b1, 1'b1, t0);
            wait_idle(3 * TIMEOUT);
        end

        // No ACK from the device.
        dev_ack = 1'b0;
        p0 = pulse_cnt;
        send(8'($urandom), 1'b0, 1'b1, 1'b1, t0);
        wait_idle(3 * TIMEOUT);
        check("noack_one_pulse", pulse_cnt - p0, 1);
        dev_ack = 1'b1;
        repeat (4 * H) @(negedge clk);

        // Device never clocks: timeout measured from SHIFT entry.
        dev_enable = 1'b0;
        send(ps2_pkg::CMD_SET_RATE, 1'b0, 1'b0, 1'b1, t0);
        n = 0;
        while (!tx_err && n < 2 * TIMEOUT) begin
            @(negedge clk);
            n++;
        end
        check("timeout_cycles", cyc - t0, TIMEOUT);
        check("timeout_lines", {ps2_clk_drive_low, ps2_data_drive_low}, 0);
        wait_idle(100);
        dev_enable = 1'b1;

        // Short glitch on the clock line must not advance a bit.
        dev_glitch = 1'b1;
        send(8'($urandom), 1'b1, 1'b1, 1'b1, t0);
        wait_idle(3 * TIMEOUT);
        dev_glitch = 1'b0;

        // Request mid-frame is ignored.
        send(8'hA3, 1'b1, 1'b1, 1'b1, t0);
        repeat (200) @(negedge clk);
        tx_data  = 8'h55;
        tx_valid = 1'b1;
        check("midframe_not_ready", tx_ready, 0);
        repeat (100) @(negedge clk);
        tx_valid = 1'b0;
        wait_idle(3 * TIMEOUT);
        repeat (5) @(negedge clk);
        check("midframe_no_extra", busy, 0);

        // Reset around bit 4: lines released in the same cycle, no pulses.
        p0 = pulse_cnt;
        send(8'($urandom), 1'b1, 1'b1, 1'b0, t0);
        repeat (H + 4 * (2 * H + 1) + H / 2) @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check("rst_mid_lines", {ps2_clk_drive_low, ps2_data_drive_low}, 0);
        check("rst_mid_busy", busy, 0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        n = 0;
        while (dev_active && n < 3000) begin
            @(negedge clk);
            n++;
        end
        repeat (20) @(negedge clk);
        check("rst_mid_no_pulse", pulse_cnt - p0, 0);
        cap_q.delete();

        // Recovery after the aborted frame.
        send(ps2_pkg::CMD_ENABLE, 1'b1, 1'b1, 1'b1, t0);
        wait_idle(3 * TIMEOUT);

        repeat (20) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- PS/2 host-to-device transmitter, the opposite direction of the existing mouse receive path.
- Sends one command byte to the mouse (e.g. 0xF4 enable reporting, 0xFF reset) over the open-drain PS2Clk/PS2Data lines.
- Sits beside the mouse controller in the 100 MHz domain; the top-level tri-states drive low when *_drive_low=1 and release the line otherwise.
- Asserts busy so the receive path ignores the line while a frame is in flight.

Parameters:
- INHIBIT_CYCLES, 12000: host clock-low inhibit time (120 us @ 100 MHz; protocol minimum is 100 us).
- TIMEOUT_CYCLES, 1500000: whole-frame timeout from release of clock (15 ms).
- FILTER_LEN, 8: consecutive equal synchronized samples needed to change a filtered line value.

Ports:
- clk  in  1  system clock (100 MHz domain).
- rst  in  1  asynchronous, active-low reset.
- tx_data  in  8  command byte.
- tx_valid  in  1  request to send tx_data.
- tx_ready  out  1  high only in IDLE.
- ps2_clk_in  in  1  raw PS2Clk pad value.
- ps2_data_in  in  1  raw PS2Data pad value.
- ps2_clk_drive_low  out  1  1 = pull PS2Clk low.
- ps2_data_drive_low  out  1  1 = pull PS2Data low.
- busy  out  1  high in every state except IDLE.
- tx_done  out  1  one-cycle pulse: frame sent and acknowledged.
- tx_err  out  1  one-cycle pulse: no ACK or timeout.

Behaviour:
- Reset (rst=0, async): state IDLE, both drive_low=0 (lines released), tx_ready=1, busy=0, tx_done=0, tx_err=0, all counters 0.
- Input conditioning: each raw line goes through a 2-flop synchronizer, then the filter. The filtered value changes only after FILTER_LEN identical samples. Filtered values reset to 1.
- A filtered PS2Clk falling edge (fall) is a single-cycle event, raised FILTER_LEN+2 cycles after the pad edge.
- Handshake: accept when tx_valid && tx_ready. At accept, latch tx_data and compute odd parity par = ~^tx_data. tx_valid outside IDLE is ignored; no queueing.
- IDLE: lines released. On accept, go to INHIBIT next cycle.
- INHIBIT: clk_drive_low=1 for exactly INHIBIT_CYCLES cycles, then go to START.
- START: clk_drive_low=1 and data_drive_low=1 for 1 cycle. Then SHIFT with clk released and data held low as the start bit. The timeout counter is cleared here.
- SHIFT: bit index n runs 0..9, advancing on each fall.
  - Falls 1..8 drive data bit n-1, LSB first; data_drive_low = ~bit.
  - Fall 9 drives par.
  - Fall 10 releases data (stop bit = 1), then go to ACK.
- ACK: on the next fall, sample the filtered data line. 0 means ACK OK, go to RELEASE. 1 means go to ERR.
- RELEASE: wait until filtered clock=1 and data=1, then go to DONE.
- DONE: pulse tx_done for 1 cycle, go to IDLE.
- ERR: pulse tx_err for 1 cycle, release both lines, go to IDLE.
- Timeout: in SHIFT, ACK or RELEASE, if the counter reaches TIMEOUT_CYCLES-1, go to ERR. Timeout takes priority over a coincident fall.
- Line ownership: drive_low outputs are registered. Clock is never driven low outside INHIBIT/START. Data is never driven outside START/SHIFT.
- Counter widths: inhibit counter 14 bits, timeout counter 21 bits, bit index 4 bits. No wrap is possible before a state exit.
- Reset mid-frame: lines released immediately. No tx_done/tx_err pulse. The device recovers via its own timeout.

Decomposition:
- Package ps2_pkg:
  - State enum: IDLE, INHIBIT, START, SHIFT, ACK, RELEASE, DONE, ERR.
  - Frame constants: DATA_BITS=8, PARITY_IDX=8, STOP_IDX=9.
  - Command codes: CMD_RESET=8'hFF, CMD_ENABLE=8'hF4, CMD_SET_RATE=8'hF3.
- Sub-module ps2_line_filter: synchronizer, FILTER_LEN debounce and falling-edge strobe. Instantiated twice (clock and data).

Test Plan:
- Send 0xF4, device model clocks at ~12.5 kHz and ACKs.
  - Bits seen on rising edges: start 0, then 0,0,1,0,1,1,1,1, parity 0, stop 1.
  - tx_done pulses once; busy clears.
- Send 0xFF and 0x00 -> parity bit 1 in both cases, tx_done asserted.
- Accept 0xF4 -> ps2_clk_drive_low high for exactly 12000 cycles, then 1 cycle with both lines driven low, then clock released.
- Device holds data high at the ACK clock -> tx_err pulses once, tx_done stays 0, lines released, tx_ready=1.
- Device never clocks -> tx_err exactly 1500000 cycles after entering SHIFT, both drive_low=0.
- Robustness:
  - 5-cycle glitch on PS2Clk -> no bit advance.
  - tx_valid=1 with 0x55 mid-frame -> ignored; the in-flight frame is unchanged.
  - rst=0 during bit 4 -> both drive_low=0 in the same cycle, no pulses.
